// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the pipelined CPU: boot loader FSM that fills
// IMEM from a little-endian byte stream, then serves fetch and data traffic.
// Optional macro DMEM_INIT_CLEAR_EN: zero all of DMEM during LOAD and hold
// COMMIT until the clear has finished.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   load_valid/byte/last/ready loader byte stream
//   cpu_rst_n, boot_done       CPU release, high in RUN
//   load_err, load_words       IMEM overflow flag, words written to IMEM
//   inst_addr, instruction     combinational fetch port
//   data_addr/wen/write/read   data port, sync write, comb read
module cpu_mem_responder #(
    parameter int IMEM_AW = 8,
    parameter int DMEM_AW = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_valid,
    input  logic [7:0]         load_byte,
    input  logic               load_last,
    output logic               load_ready,
    output logic               cpu_rst_n,
    output logic               boot_done,
    output logic               load_err,
    output logic [IMEM_AW:0]   load_words,
    input  logic [31:0]        inst_addr,
    output logic [31:0]        instruction,
    input  logic [31:0]        data_addr,
    input  logic               data_wen,
    input  logic [31:0]        data_write,
    output logic [31:0]        data_read
);

    localparam int IDEPTH = 1 << IMEM_AW;
    localparam int DDEPTH = 1 << DMEM_AW;
    localparam logic [IMEM_AW:0] IFULL = (IMEM_AW+1)'(IDEPTH);

    typedef enum logic [1:0] {
        LOAD,
        COMMIT,
        RUN
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         lane_q, lane_d;
    logic [31:0]        asm_q, asm_d;
    logic [IMEM_AW:0]   words_q, words_d;
    logic               err_q, err_d;
    logic               cpu_rst_n_q, cpu_rst_n_d;
    logic               boot_done_q, boot_done_d;

    logic [31:0]        imem [IDEPTH];
    logic [31:0]        dmem [DDEPTH];

    logic               imem_we;
    logic [IMEM_AW-1:0] imem_wa;
    logic [31:0]        imem_wd;
    logic [31:0]        beat_word;
    logic               clr_done;
    logic               inst_hit;
    logic               d_in_range;

`ifdef DMEM_INIT_CLEAR_EN
    localparam logic [DMEM_AW:0] DFULL = (DMEM_AW+1)'(DDEPTH);
    logic [DMEM_AW:0]   clr_q, clr_d;

    assign clr_done = (clr_q == DFULL);

    always_comb begin
        clr_d = clr_q;
        if (!clr_done) begin
            clr_d = clr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_q <= '0;
        end else begin
            clr_q <= clr_d;
        end
    end
`else
    assign clr_done = 1'b1;
`endif

    // Incoming byte merged into the current lane; lanes above it are still 0.
    assign beat_word = asm_q | (32'(load_byte) << {lane_q, 3'b000});

    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        asm_d       = asm_q;
        words_d     = words_q;
        err_d       = err_q;
        cpu_rst_n_d = cpu_rst_n_q;
        boot_done_d = boot_done_q;
        imem_we     = 1'b0;
        imem_wa     = words_q[IMEM_AW-1:0];
        imem_wd     = beat_word;
        unique case (state_q)
            LOAD: begin
                if (load_valid) begin
                    lane_d = lane_q + 2'd1;
                    asm_d  = beat_word;
                    if (lane_q == 2'd3 || load_last) begin
                        lane_d = '0;
                        asm_d  = '0;
                        // A full IMEM drops the word but keeps accepting bytes.
                        if (words_q == IFULL) begin
                            err_d = 1'b1;
                        end else begin
                            imem_we = 1'b1;
                            words_d = words_q + 1'b1;
                        end
                    end
                    if (load_last) begin
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                if (clr_done) begin
                    state_d     = RUN;
                    cpu_rst_n_d = 1'b1;
                    boot_done_d = 1'b1;
                end
            end
            RUN: begin
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD;
            lane_q      <= '0;
            asm_q       <= '0;
            words_q     <= '0;
            err_q       <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            boot_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            asm_q       <= asm_d;
            words_q     <= words_d;
            err_q       <= err_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            boot_done_q <= boot_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && imem_we) begin
            imem[imem_wa] <= imem_wd;
        end
    end

    assign d_in_range = (data_addr[31:DMEM_AW] == '0);

    // The clear finishes before RUN, so it never competes with CPU writes.
    always_ff @(posedge clk) begin
        if (!rst) begin
`ifdef DMEM_INIT_CLEAR_EN
            if (!clr_done) begin
                dmem[clr_q[DMEM_AW-1:0]] <= '0;
            end else
`endif
            if (state_q == RUN && data_wen && d_in_range) begin
                dmem[data_addr[DMEM_AW-1:0]] <= data_write;
            end
        end
    end

    assign inst_hit    = (state_q == RUN) && (inst_addr[31:IMEM_AW] == '0);
    assign instruction = inst_hit ? imem[inst_addr[IMEM_AW-1:0]] : '0;
    assign data_read   = d_in_range ? dmem[data_addr[DMEM_AW-1:0]] : '0;

    assign load_ready = (state_q == LOAD);
    assign cpu_rst_n  = cpu_rst_n_q;
    assign boot_done  = boot_done_q;
    assign load_err   = err_q;
    assign load_words = words_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder with a behavioural model of
// the boot image, IMEM and DMEM contents, checked on every falling edge.
module tb_cpu_mem_responder;

    localparam int IA = 4;
    localparam int DA = 4;
    localparam int ID = 1 << IA;
    localparam int DD = 1 << DA;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_valid;
    logic [7:0]    load_byte;
    logic          load_last;
    logic          load_ready;
    logic          cpu_rst_n;
    logic          boot_done;
    logic          load_err;
    logic [IA:0]   load_words;
    logic [31:0]   inst_addr;
    logic [31:0]   instruction;
    logic [31:0]   data_addr;
    logic          data_wen;
    logic [31:0]   data_write;
    logic [31:0]   data_read;

    cpu_mem_responder #(.IMEM_AW(IA), .DMEM_AW(DA)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_byte  (load_byte),
        .load_last  (load_last),
        .load_ready (load_ready),
        .cpu_rst_n  (cpu_rst_n),
        .boot_done  (boot_done),
        .load_err   (load_err),
        .load_words (load_words),
        .inst_addr  (inst_addr),
        .instruction(instruction),
        .data_addr  (data_addr),
        .data_wen   (data_wen),
        .data_write (data_write),
        .data_read  (data_read)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: age 0 = loading, 1 = one cycle after the last beat, 2 = running.
    int          m_age = 0;
    int          m_n = 0;
    int          m_edges = 0;
    bit          m_started = 0;
    logic [7:0]  m_bytes[$];
    logic [31:0] m_imem[ID];
    bit          m_ik[ID];
    logic [31:0] m_dmem[DD];
    bit          m_dk[DD];
    int          age_pre, edges_pre, w;
    logic [31:0] word;
    bit          clr_ok;

    always @(posedge clk) begin
        age_pre   = m_age;
        edges_pre = m_edges;
        m_started = 1;
        if (rst) begin
            m_age   = 0;
            m_n     = 0;
            m_edges = 0;
            m_bytes.delete();
        end else begin
`ifdef DMEM_INIT_CLEAR_EN
            if (edges_pre < DD) begin
                m_dmem[edges_pre] = '0;
                m_dk[edges_pre]   = 1;
            end
            clr_ok = (edges_pre >= DD);
`else
            clr_ok = 1;
`endif
            if (m_edges < 100000) m_edges++;
            if (age_pre == 2 && data_wen && data_addr < DD) begin
                m_dmem[data_addr[DA-1:0]] = data_write;
                m_dk[data_addr[DA-1:0]]   = 1;
            end
            if (age_pre == 0 && load_valid) begin
                m_bytes.push_back(load_byte);
                m_n++;
                if (m_n % 4 == 0 || load_last) begin
                    w = (m_n - 1) / 4;
                    word = '0;
                    for (int j = 0; j < 4; j++) begin
                        if (w * 4 + j < m_n)
                            word |= 32'(m_bytes[w * 4 + j]) << (8 * j);
                    end
                    if (w < ID) begin
                        m_imem[w] = word;
                        m_ik[w]   = 1;
                    end
                end
                if (load_last) m_age = 1;
            end else if (age_pre == 1 && clr_ok) begin
                m_age = 2;
            end
        end
    end

    int att;
    always @(negedge clk) begin
        if (m_started) begin
            att = (m_age == 0) ? m_n / 4 : (m_n + 3) / 4;
            chk("load_ready", load_ready, m_age == 0);
            chk("cpu_rst_n", cpu_rst_n, m_age >= 2);
            chk("boot_done", boot_done, m_age >= 2);
            chk("load_words", load_words, (att > ID) ? ID : att);
            chk("load_err", load_err, att > ID);
            if (m_age < 2 || inst_addr >= ID)
                chk("instruction", instruction, 0);
            else if (m_ik[inst_addr[IA-1:0]])
                chk("instruction", instruction, m_imem[inst_addr[IA-1:0]]);
            if (data_addr >= DD)
                chk("data_read", data_read, 0);
            else if (m_dk[data_addr[DA-1:0]])
                chk("data_read", data_read, m_dmem[data_addr[DA-1:0]]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last);
        load_valid = 1;
        load_byte  = b;
        load_last  = last;
        tick();
        load_valid = 0;
        load_last  = 0;
        load_byte  = 8'($urandom);
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic wait_boot();
        for (int i = 0; i < 200 && m_age < 2; i++) tick();
        tick();
        @(negedge clk);
        chk("boot_timeout", boot_done, 1);
    endtask

    task automatic send_random(input int nb);
        for (int i = 0; i < nb; i++) begin
            repeat ($urandom_range(0, 2)) begin
                load_last = 1'($urandom);
                tick();
                load_last = 0;
            end
            send_byte(8'($urandom), i == nb - 1);
        end
    endtask

    initial begin
        rst = 1; load_valid = 0; load_byte = 0; load_last = 0;
        inst_addr = 0; data_addr = 0; data_wen = 0; data_write = 0;
        tick();
        tick();
        rst = 0;
        @(negedge clk);
        chk("rst_cpu_rst_n", cpu_rst_n, 0);
        chk("rst_load_words", load_words, 0);
        chk("rst_load_ready", load_ready, 1);

        send_byte(8'h20, 0); send_byte(8'h00, 0);
        send_byte(8'h01, 0); send_byte(8'h20, 0);
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'h00, 0); send_byte(8'h00, 1);
`ifndef DMEM_INIT_CLEAR_EN
        @(negedge clk);
        chk("commit_cpu_rst_n", cpu_rst_n, 0);
        tick();
        @(negedge clk);
        chk("release_cpu_rst_n", cpu_rst_n, 1);
`endif
        wait_boot();
        inst_addr = 0;
        @(negedge clk);
        chk("imgA_w0", instruction, 32'h20010020);
        chk("imgA_words", load_words, 2);
        inst_addr = 1;
        @(negedge clk);
        chk("imgA_w1", instruction, 32'h0);

        do_reset();
        send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 1);
        wait_boot();
        inst_addr = 0;
        @(negedge clk);
        chk("imgB_w0", instruction, 32'h00CCBBAA);
        chk("imgB_words", load_words, 1);

        do_reset();
        send_random(4 * (ID + 1));
        wait_boot();
        chk("ovf_err", load_err, 1);
        chk("ovf_words", load_words, ID);
        chk("ovf_release", cpu_rst_n, 1);

        do_reset();
        send_random($urandom_range(1, 40));
        wait_boot();
        data_wen = 1; data_addr = 0; data_write = 32'h11111111;
        tick();
        for (int i = 0; i < 300; i++) begin
            data_wen   = 1'($urandom);
            data_write = $urandom;
            data_addr  = ($urandom_range(0, 9) < 7) ?
                         $urandom_range(1, DD - 1) : $urandom_range(DD, 300);
            inst_addr  = ($urandom_range(0, 9) < 8) ?
                         $urandom_range(0, ID - 1) : $urandom;
            tick();
        end

        data_wen = 1; data_addr = 5; data_write = 32'hDEADBEEF;
        tick();
        data_wen = 0;
        @(negedge clk);
        chk("wr_visible", data_read, 32'hDEADBEEF);
        data_wen = 1; data_addr = 32'h100; data_write = 32'h12345678;
        @(negedge clk);
        chk("oor_read", data_read, 0);
        tick();
        data_wen = 0; data_addr = 0;
        @(negedge clk);
        chk("oor_no_alias", data_read, 32'h11111111);

        send_byte(8'h55, 0); send_byte(8'h66, 0);
        inst_addr = 0;
        do_reset();
        @(negedge clk);
        chk("midrst_cpu_rst_n", cpu_rst_n, 0);
        chk("midrst_instr", instruction, 0);
        chk("midrst_words", load_words, 0);
        send_byte(8'h77, 0); send_byte(8'h88, 0);
        do_reset();
        send_byte(8'h01, 0); send_byte(8'h02, 0);
        send_byte(8'h03, 0); send_byte(8'h04, 1);
        wait_boot();
        inst_addr = 0;
        @(negedge clk);
        chk("reboot_w0", instruction, 32'h04030201);
`ifdef DMEM_INIT_CLEAR_EN
        data_addr = 3;
        @(negedge clk);
        chk("clr_dmem3", data_read, 0);
`endif
        for (int i = 0; i < ID; i++) begin
            inst_addr = i;
            data_addr = i;
            tick();
        end
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
